// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, FSM states, helpers.
package seq_pkg;

  localparam logic [3:0] SEQ_OP_NOP = 4'h0;
  localparam logic [3:0] SEQ_OP_LDI = 4'h1;
  localparam logic [3:0] SEQ_OP_LDR = 4'h2;
  localparam logic [3:0] SEQ_OP_CMD = 4'h3;
  localparam logic [3:0] SEQ_OP_DMP = 4'h4;
  localparam logic [3:0] SEQ_OP_EQI = 4'h5;
  localparam logic [3:0] SEQ_OP_EQR = 4'h6;
  localparam logic [3:0] SEQ_OP_JXI = 4'h7;
  localparam logic [3:0] SEQ_OP_JXR = 4'h8;
  localparam logic [3:0] SEQ_OP_JZI = 4'h9;
  localparam logic [3:0] SEQ_OP_JZR = 4'hA;
  localparam logic [3:0] SEQ_OP_CAL = 4'hB;
  localparam logic [3:0] SEQ_OP_RET = 4'hC;
  localparam logic [3:0] SEQ_OP_WAT = 4'hD;

  // Widest output bank the onehot helper can describe; callers size-cast down.
  localparam int SEQ_MAX_OUT = 4096;

  typedef enum logic [1:0] {
    SEQ_RESET = 2'd0,
    SEQ_READY = 2'd1,
    SEQ_WAIT  = 2'd2,
    SEQ_ERROR = 2'd3
  } seq_state_t;

  // One-hot channel select; out-of-range channels give an all-zero mask.
  function automatic logic [SEQ_MAX_OUT-1:0] seq_onehot(input int unsigned dst,
                                                        input int unsigned n);
    seq_onehot = '0;
    if (dst < n && dst < SEQ_MAX_OUT) seq_onehot[dst] = 1'b1;
  endfunction

  // Debug names, for simulation messages only.
  function automatic string seq_state_name(input seq_state_t s);
    case (s)
      SEQ_RESET: return "RESET";
      SEQ_READY: return "READY";
      SEQ_WAIT:  return "WAIT";
      default:   return "ERROR";
    endcase
  endfunction

  function automatic string seq_op_name(input logic [3:0] op);
    case (op)
      SEQ_OP_NOP: return "NOP";
      SEQ_OP_LDI: return "LDI";
      SEQ_OP_LDR: return "LDR";
      SEQ_OP_CMD: return "CMD";
      SEQ_OP_DMP: return "DMP";
      SEQ_OP_EQI: return "EQI";
      SEQ_OP_EQR: return "EQR";
      SEQ_OP_JXI: return "JXI";
      SEQ_OP_JXR: return "JXR";
      SEQ_OP_JZI: return "JZI";
      SEQ_OP_JZR: return "JZR";
      SEQ_OP_CAL: return "CAL";
      SEQ_OP_RET: return "RET";
      SEQ_OP_WAT: return "WAT";
      default:    return "ILL";
    endcase
  endfunction

endpackage

// File: rtl/seq_lifo.sv
// Return-address stack: Depth x Width LIFO with full/empty flags.
module seq_lifo #(
  parameter int Width = 8,
  parameter int Depth = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int PW = $clog2(Depth + 1);

  logic [Width-1:0] mem [Depth];
  logic [PW-1:0]    sp;
  logic [AW-1:0]    rd_idx;
  logic [AW-1:0]    wr_idx;

  assign full   = (sp == PW'(Depth));
  assign empty  = (sp == '0);
  assign rd_idx = AW'(sp - PW'(1));
  assign wr_idx = AW'(sp);
  // Top of stack is zero when empty so the caller never sees stale data.
  assign rdata  = empty ? '0 : mem[rd_idx];

  // Push has priority; overflow/underflow requests are dropped (caller traps them).
  always_ff @(posedge clock) begin
    if (reset) begin
      sp <= '0;
      for (int i = 0; i < Depth; i++) mem[i] <= '0;
    end else if (push && !full) begin
      mem[wr_idx] <= wdata;
      sp          <= sp + PW'(1);
    end else if (pop && !empty) begin
      sp <= sp - PW'(1);
    end
  end

endmodule

// File: rtl/seq_stack.sv
// Parametrised instruction sequencer with call/return stack, timed wait and error trap.
module seq_stack
  import seq_pkg::*;
#(
  parameter int Width      = 8,
  parameter int InRegs     = 4,
  parameter int OutRegs    = 8,
  parameter int StackDepth = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [Width+3:0]        inst,
  input  logic                    inst_en,
  input  logic [InRegs*Width-1:0] ireg,
  output logic [Width-1:0]        next,
  output logic [Width+3:0]        oreg,
  output logic [OutRegs-1:0]      oreg_wen,
  output logic                    busy,
  output logic                    error
);

  localparam int SrcW = $clog2(InRegs);
  localparam int DstW = $clog2(OutRegs);

  seq_state_t                   state_q, state_d;
  logic [Width-1:0]             pc_q, pc_d, t_q, t_d, cnt_q, cnt_d;
  logic [Width+3:0]             oreg_q, oreg_d;
  logic [OutRegs-1:0]           wen_q, wen_d;
  logic [InRegs-1:0][Width-1:0] ireg_a;
  logic [3:0]                   op, cmd;
  logic [Width-1:0]             imm, pc_inc, src_val, top;
  logic [SrcW-1:0]              src;
  logic [DstW-1:0]              dst;
  logic                         push, pop, full, empty;

  assign ireg_a  = ireg;
  assign op      = inst[Width+3:Width];
  assign imm     = inst[Width-1:0];
  assign src     = imm[SrcW-1:0];
  assign dst     = imm[DstW-1:0];
  assign cmd     = imm[Width-1:Width-4];
  assign src_val = ireg_a[src];
  assign pc_inc  = pc_q + Width'(1);

  seq_lifo #(.Width(Width), .Depth(StackDepth)) u_lifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (pc_inc),
    .rdata (top),
    .full  (full),
    .empty (empty)
  );

  // State, program counter, transfer register, wait counter and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= SEQ_RESET;
      pc_q    <= '0;
      t_q     <= '0;
      cnt_q   <= '0;
      oreg_q  <= '0;
      wen_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      t_q     <= t_d;
      cnt_q   <= cnt_d;
      oreg_q  <= oreg_d;
      wen_q   <= wen_d;
    end
  end

  // Decode/execute; outputs default to zero so each CMD/DMP pulses for one cycle.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    t_d     = t_q;
    cnt_d   = cnt_q;
    oreg_d  = '0;
    wen_d   = '0;
    push    = 1'b0;
    pop     = 1'b0;
    case (state_q)
      SEQ_RESET: state_d = SEQ_READY;
      SEQ_READY: begin
        if (inst_en) begin
          pc_d = pc_inc;
          case (op)
            SEQ_OP_NOP: ;
            SEQ_OP_LDI: t_d = imm;
            SEQ_OP_LDR: t_d = src_val;
            SEQ_OP_CMD: begin
              oreg_d = {cmd, t_q};
              wen_d  = OutRegs'(seq_onehot(32'(dst), 32'(OutRegs)));
            end
            SEQ_OP_DMP: begin
              oreg_d = {4'h0, t_q};
              wen_d  = OutRegs'(seq_onehot(32'(dst), 32'(OutRegs)));
            end
            SEQ_OP_EQI: t_d = Width'(t_q == imm);
            SEQ_OP_EQR: t_d = Width'(t_q == src_val);
            SEQ_OP_JXI: pc_d = imm;
            SEQ_OP_JXR: pc_d = src_val;
            SEQ_OP_JZI: if (t_q == '0) pc_d = imm;
            SEQ_OP_JZR: if (t_q == '0) pc_d = src_val;
            SEQ_OP_CAL: begin
              if (full) begin
                state_d = SEQ_ERROR;
                pc_d    = pc_q;
              end else begin
                push = 1'b1;
                pc_d = imm;
              end
            end
            SEQ_OP_RET: begin
              if (empty) begin
                state_d = SEQ_ERROR;
                pc_d    = pc_q;
              end else begin
                pop  = 1'b1;
                pc_d = top;
              end
            end
            SEQ_OP_WAT: begin
              cnt_d = imm;
              // PC stays on the WAT until the count expires.
              if (imm != '0) begin
                state_d = SEQ_WAIT;
                pc_d    = pc_q;
              end
            end
            default: begin
              state_d = SEQ_ERROR;
              pc_d    = pc_q;
            end
          endcase
        end
      end
      SEQ_WAIT: begin
        cnt_d = cnt_q - Width'(1);
        if (cnt_q <= Width'(1)) begin
          state_d = SEQ_READY;
          pc_d    = pc_inc;
        end
      end
      default: ;
    endcase
  end

  assign next     = pc_q;
  assign oreg     = oreg_q;
  assign oreg_wen = wen_q;
  assign busy     = (state_q != SEQ_READY);
  assign error    = (state_q == SEQ_ERROR);

endmodule

// File: tb/tb_seq_stack.sv
// Directed bench for seq_stack: default 8-bit instance plus a 12-bit wide variant.
module tb_seq_stack;
  import seq_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] inst = '0;
  logic        inst_en = 1'b0;
  logic [31:0] ireg = '0;
  logic [7:0]  next;
  logic [11:0] oreg;
  logic [7:0]  oreg_wen;
  logic        busy, error;

  logic [15:0] inst2 = '0;
  logic        inst_en2 = 1'b0;
  logic [95:0] ireg2 = '0;
  logic [11:0] next2;
  logic [15:0] oreg2;
  logic [15:0] oreg_wen2;
  logic        busy2, error2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  seq_stack dut (
    .clock(clock), .reset(reset), .inst(inst), .inst_en(inst_en), .ireg(ireg),
    .next(next), .oreg(oreg), .oreg_wen(oreg_wen), .busy(busy), .error(error)
  );

  seq_stack #(.Width(12), .InRegs(8), .OutRegs(16), .StackDepth(2)) dut_w (
    .clock(clock), .reset(reset), .inst(inst2), .inst_en(inst_en2), .ireg(ireg2),
    .next(next2), .oreg(oreg2), .oreg_wen(oreg_wen2), .busy(busy2), .error(error2)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic exec(input logic [3:0] op, input logic [7:0] imm);
    inst    = {op, imm};
    inst_en = 1'b1;
    tick();
    inst_en = 1'b0;
  endtask

  task automatic exec2(input logic [3:0] op, input logic [11:0] imm);
    inst2    = {op, imm};
    inst_en2 = 1'b1;
    tick();
    inst_en2 = 1'b0;
  endtask

  initial begin
    ireg[15:8]  = 8'h10;
    ireg[23:16] = 8'h33;
    ireg[31:24] = 8'h07;
    ireg2[6*12 +: 12] = 12'hABC;

    // reset values
    tick(); tick();
    chk("rst_next", 32'(next), 32'h0);
    chk("rst_oreg", 32'(oreg), 32'h0);
    chk("rst_wen", 32'(oreg_wen), 32'h0);
    chk("rst_busy", 32'(busy), 32'h1);
    chk("rst_error", 32'(error), 32'h0);
    reset = 1'b0;
    tick();
    chk("ready_busy", 32'(busy), 32'h0);

    // wide variant: 3-bit src, 4-bit dst, 16-bit oreg
    exec2(SEQ_OP_LDR, 12'h006);
    exec2(SEQ_OP_CMD, 12'h90D);
    chk("w_oreg", 32'(oreg2), 32'h9ABC);
    chk("w_wen", 32'(oreg_wen2), 32'h2000);
    chk("w_next", 32'(next2), 32'h2);

    // LDI / CMD pulse
    exec(SEQ_OP_LDI, 8'h5A);
    exec(SEQ_OP_CMD, 8'h32);
    chk("cmd_oreg", 32'(oreg), 32'h35A);
    chk("cmd_wen", 32'(oreg_wen), 32'h04);
    chk("cmd_next", 32'(next), 32'h2);
    tick();
    chk("cmd_pulse_wen", 32'(oreg_wen), 32'h0);
    chk("cmd_pulse_oreg", 32'(oreg), 32'h0);
    chk("idle_next", 32'(next), 32'h2);

    // LDR / EQI / DMP / JZI
    exec(SEQ_OP_LDR, 8'h01);
    exec(SEQ_OP_EQI, 8'h10);
    exec(SEQ_OP_DMP, 8'h07);
    chk("dmp_oreg", 32'(oreg), 32'h001);
    chk("dmp_wen", 32'(oreg_wen), 32'h80);
    exec(SEQ_OP_JZI, 8'h40);
    chk("jzi_nojump", 32'(next), 32'h6);
    exec(SEQ_OP_EQI, 8'h00);
    exec(SEQ_OP_JZI, 8'h40);
    chk("jzi_jump", 32'(next), 32'h40);

    // jumps, call/return
    exec(SEQ_OP_JXI, 8'h05);
    chk("jxi", 32'(next), 32'h5);
    exec(SEQ_OP_CAL, 8'h20);
    chk("cal", 32'(next), 32'h20);
    exec(SEQ_OP_RET, 8'h00);
    chk("ret", 32'(next), 32'h6);
    exec(SEQ_OP_JXR, 8'h01);
    chk("jxr", 32'(next), 32'h10);
    exec(SEQ_OP_JZR, 8'h02);
    chk("jzr_jump", 32'(next), 32'h33);
    exec(SEQ_OP_LDI, 8'h07);
    exec(SEQ_OP_EQR, 8'h03);
    exec(SEQ_OP_DMP, 8'h00);
    chk("eqr_oreg", 32'(oreg), 32'h001);
    chk("eqr_wen", 32'(oreg_wen), 32'h01);
    chk("eqr_next", 32'(next), 32'h36);
    exec(SEQ_OP_NOP, 8'h00);
    exec(SEQ_OP_JZR, 8'h02);
    chk("jzr_nojump", 32'(next), 32'h38);

    // WAT 0 behaves as NOP
    exec(SEQ_OP_WAT, 8'h00);
    chk("wat0_busy", 32'(busy), 32'h0);
    chk("wat0_next", 32'(next), 32'h39);

    // WAT 3 at 0xFF: three busy cycles, PC wraps to 0; inst_en ignored meanwhile
    exec(SEQ_OP_JXI, 8'hFF);
    exec(SEQ_OP_WAT, 8'h03);
    chk("wat_busy1", 32'(busy), 32'h1);
    chk("wat_next_hold", 32'(next), 32'hFF);
    inst = {SEQ_OP_LDI, 8'hAA};
    inst_en = 1'b1;
    tick();
    chk("wat_busy2", 32'(busy), 32'h1);
    tick();
    chk("wat_busy3", 32'(busy), 32'h1);
    inst_en = 1'b0;
    tick();
    chk("wat_done_busy", 32'(busy), 32'h0);
    chk("wat_wrap_next", 32'(next), 32'h00);
    exec(SEQ_OP_DMP, 8'h01);
    chk("wat_ignore_t", 32'(oreg), 32'h001);
    chk("wat_ignore_wen", 32'(oreg_wen), 32'h02);

    // stack overflow
    exec(SEQ_OP_CAL, 8'h10);
    exec(SEQ_OP_CAL, 8'h20);
    exec(SEQ_OP_CAL, 8'h30);
    exec(SEQ_OP_DMP, 8'h00);
    exec(SEQ_OP_CAL, 8'h40);
    chk("cal4_next", 32'(next), 32'h40);
    chk("cal4_error", 32'(error), 32'h0);
    exec(SEQ_OP_CAL, 8'h50);
    chk("ovf_error", 32'(error), 32'h1);
    chk("ovf_busy", 32'(busy), 32'h1);
    chk("ovf_wen", 32'(oreg_wen), 32'h0);
    chk("ovf_next", 32'(next), 32'h40);
    exec(SEQ_OP_DMP, 8'h00);
    chk("err_ignore_wen", 32'(oreg_wen), 32'h0);
    chk("err_sticky", 32'(error), 32'h1);

    // reset from Error
    reset = 1'b1;
    tick();
    chk("err_rst_error", 32'(error), 32'h0);
    chk("err_rst_next", 32'(next), 32'h0);
    chk("err_rst_busy", 32'(busy), 32'h1);
    reset = 1'b0;
    tick();
    chk("err_rst_ready", 32'(busy), 32'h0);

    // RET on empty stack
    exec(SEQ_OP_RET, 8'h00);
    chk("unf_error", 32'(error), 32'h1);
    chk("unf_next", 32'(next), 32'h0);
    reset = 1'b1; tick(); reset = 1'b0; tick();

    // illegal opcode
    exec(4'hE, 8'h00);
    chk("ill_error", 32'(error), 32'h1);
    reset = 1'b1; tick(); reset = 1'b0; tick();

    // reset mid-Wait clears stack and counter
    exec(SEQ_OP_CAL, 8'h08);
    exec(SEQ_OP_WAT, 8'h05);
    tick();
    chk("midwait_busy", 32'(busy), 32'h1);
    reset = 1'b1;
    tick();
    chk("midwait_rst_next", 32'(next), 32'h0);
    chk("midwait_rst_busy", 32'(busy), 32'h1);
    chk("midwait_rst_wen", 32'(oreg_wen), 32'h0);
    chk("midwait_rst_oreg", 32'(oreg), 32'h0);
    reset = 1'b0;
    tick();
    chk("midwait_ready", 32'(busy), 32'h0);
    exec(SEQ_OP_RET, 8'h00);
    chk("midwait_stack_clr", 32'(error), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_stack.md
# seq_stack

Parametrised successor of the 8-bit instruction sequencer. It fetches instructions by address, moves data between input registers and output channels, and branches on a transfer register. It adds width, input-count and output-count parameters, a call/return stack, a timed wait instruction, registered outputs and a visible error flag. It sits between the instruction ROM and the command/peripheral bank.

## Interface
- `Width`, 8: data, immediate and address width; ROM depth is 2^Width.
- `InRegs`, 4: number of input registers; power of 2, between 2 and 2^(Width-4).
- `OutRegs`, 8: number of output channels; power of 2, between 2 and 2^(Width-4).
- `StackDepth`, 4: return-address stack entries; at least 1.

- `clock`  in  1: sole clock; all state changes on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `inst`  in  Width+4: `[Width+3:Width]` opcode, `[Width-1:0]` imm; src = imm low bits, dst = imm low bits, cmd = imm top 4 bits.
- `inst_en`  in  1: `inst` is valid for address `next`.
- `ireg`  in  InRegs*Width: flattened input registers; register k is `[k*Width +: Width]`.
- `next`  out  Width: fetch address (program counter).
- `oreg`  out  Width+4: output word, registered.
- `oreg_wen`  out  OutRegs: one-hot channel write enable, registered.
- `busy`  out  1: high in Reset, Wait and Error; `inst` is ignored while high.
- `error`  out  1: sticky error flag.

## Operation
- States: Reset, Ready, Wait, Error.
- Reset exits to Ready unconditionally on the next clock.
- An instruction is accepted only when state = Ready and `inst_en` = 1. Ready with `inst_en` = 0 holds all state.
- Opcodes, "PC+1" meaning the current address plus one:
  - 0 NOP: PC+1.
  - 1 LDI: T = imm.
  - 2 LDR: T = ireg[src].
  - 3 CMD: oreg = {cmd, T}, wen = onehot(dst).
  - 4 DMP: oreg = {0, T}, wen = onehot(dst).
  - 5 EQI: T = (T == imm) zero-extended.
  - 6 EQR: T = (T == ireg[src]) zero-extended.
  - 7 JXI: PC = imm.
  - 8 JXR: PC = ireg[src].
  - 9 JZI: PC = (T == 0) ? imm : PC+1.
  - A JZR: PC = (T == 0) ? ireg[src] : PC+1.
  - B CAL: push PC+1, PC = imm.
  - C RET: pop into PC.
  - D WAT: counter = imm; if imm = 0 behaves as NOP, else go to Wait.
  - E, F: illegal.
- Opcodes 0–6, B, C and D(imm = 0) advance to PC+1 unless stated otherwise.
- Wait: counter decrements once per cycle. When it reaches 1, return to Ready and set PC to the address after the WAT. WAT imm = N therefore keeps `busy` high for exactly N cycles.
- Any of these goes to Error: illegal opcode, CAL with a full stack, RET with an empty stack.
- Error is absorbing until reset. On entry: `error` = 1, `busy` = 1, `oreg`/`oreg_wen` = 0, PC frozen. No X or Z is ever driven.
- All arithmetic is mod 2^Width. PC+1 wraps from 2^Width-1 to 0, and a pushed return address wraps the same way.

## Timing
- Reset (sync): state = Reset, PC = 0, T = 0, stack pointer = 0, counter = 0. Outputs: `next` = 0, `oreg` = 0, `oreg_wen` = 0, `busy` = 1, `error` = 0.
- Ready is reached 1 cycle after `reset` deasserts.
- `next` updates the cycle after acceptance. The ROM is assumed combinational, or the upstream holds `inst_en` low until data for `next` is valid.
- `oreg`/`oreg_wen` are valid for exactly one cycle, the cycle after a CMD/DMP is accepted, and are zero otherwise. Back-to-back CMDs give back-to-back pulses.
- T, PC and stack take effect for the instruction accepted on the following cycle; there are no hazards.
- `reset` asserted mid-Wait or in Error wins: next cycle is Reset, and stack and counter are cleared.
- `inst_en` during Wait or Error is ignored and has no side effect.

## Structure
- Shared package `seq_pkg`:
  - opcode constants `SEQ_OP_*`;
  - state enum `seq_state_t` (Reset, Ready, Wait, Error);
  - function `seq_onehot(dst, OutRegs)`.
- One sub-module, `seq_lifo`: StackDepth × Width with push/pop, full/empty flags and synchronous reset.
- The debug state/opcode name strings live in the package and are used only in simulation.

## Test plan
- Reset then LDI 0x5A, CMD cmd = 3 dst = 2 -> `oreg` = 0x35A and `oreg_wen` = 0x04 for one cycle; `next` = 2.
- `ireg[1]` = 0x10; LDR src = 1, EQI 0x10, JZI 0x40 -> T = 1, no jump, `next` = 3. Then EQI 0x00, JZI 0x40 -> `next` = 0x40.
- CAL 0x20 at address 5, RET at 0x20 -> `next` goes 0x20 then 6. StackDepth+1 nested CALs -> `error` = 1, `busy` = 1, `oreg_wen` = 0.
- WAT 3 at address 0xFF -> `busy` high for 3 cycles, then `next` = 0x00 (wrap). WAT 0 -> no busy cycle.
- Opcode 0xE -> Error. `reset` pulsed mid-Wait -> all outputs return to reset values, Ready after 1 cycle.
- Sweep InRegs = 2/8 and OutRegs = 4/16 with Width = 12 -> correct src/dst decoding and `oreg` width.
